muldiv_seq: RTL

//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage. Replaces the single-cycle */÷ path:

---
 rtl/muldiv_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one iteration per cycle.
// The pipeline is stalled while an op runs. The {hi,lo} result is delivered
// with a one-cycle write strobe.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cancel,
    input  logic             read_hilo,
    output logic             stall_o,
    output logic             busy_o,
    output logic             hi_lo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic [2*WIDTH-1:0]   r_acc;      // MUL: product; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   r_mcand;    // shifted multiplicand (MUL only)
    logic [WIDTH-1:0]     r_b;        // MUL: multiplier, shifted right; DIV: divisor
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_accept;
    logic                 w_div0;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_diff;
    logic                 w_q_bit;
    logic [2*WIDTH-1:0]   w_div_step;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    // The magnitude of -2^(W-1) is 2^(W-1). That value still fits W bits when
    // the operand is read as unsigned, so no extra bit is needed here.
    assign w_accept = (r_state == S_IDLE) && start && !cancel;
    assign w_div0   = op[1] && (operand_b == '0);
    assign w_mag_a  = (op[0] && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign w_mag_b  = (op[0] && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // Restoring divide step. The remainder is always below the divisor, so the
    // shifted remainder fits W+1 bits. The W+1-bit difference keeps a valid sign bit.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_q_bit    = !w_diff[WIDTH];
    assign w_div_step = {(w_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_q_bit};

    // Sign fix-up of the magnitude result. Sign flags are zero for unsigned ops.
    always_comb begin
        w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_acc[WIDTH-1:0];
        if (r_is_div) begin
            if (r_sign_a ^ r_sign_b) w_fix_lo = -r_acc[WIDTH-1:0];
            if (r_sign_a)            w_fix_hi = -r_acc[2*WIDTH-1:WIDTH];
        end else if (r_sign_a ^ r_sign_b) begin
            {w_fix_hi, w_fix_lo} = -r_acc;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic. Cancel aborts RUN/FIX, but a result in DONE still commits.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_div0 ? S_DONE : S_RUN;
            S_RUN:  if (cancel) w_state_next = S_IDLE;
                    else if (r_cnt == CNT_W'(WIDTH - 1)) w_state_next = S_FIX;
            S_FIX:  w_state_next = cancel ? S_IDLE : S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state. DONE releases the stall because HI/LO forwards.
    always_comb begin
        busy_o   = (r_state != S_IDLE);
        hi_lo_we = (r_state == S_DONE);
        stall_o  = w_accept || (r_state == S_RUN) || (r_state == S_FIX) ||
                   (read_hilo && busy_o && (r_state != S_DONE));
    end

    // Datapath: operand capture, per-cycle iteration, and result commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cnt    <= '0;
                    r_is_div <= op[1];
                    r_sign_a <= op[0] && operand_a[WIDTH-1];
                    r_sign_b <= op[0] && operand_b[WIDTH-1];
                    r_acc    <= op[1] ? {{WIDTH{1'b0}}, w_mag_a} : '0;
                    r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                    r_b      <= w_mag_b;
                    if (w_div0) begin
                        r_hi <= operand_a;
                        r_lo <= '1;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc <= w_div_step;
                    end else begin
                        if (r_b[0]) r_acc <= r_acc + r_mcand;
                        r_mcand <= r_mcand << 1;
                        r_b     <= r_b >> 1;
                    end
                end
                S_FIX: if (!cancel) begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
